evo_truth_table_tester: RTL
===========================

Name: evo_truth_table_tester

Overview:
- Sequences an exhaustive truth-table test of one evolved LCELL circuit-under-test (CUT): a 4-input, 1-output combinational netlist that may contain feedback loops.
- Drives every input vector in ascending order and waits a settle time before sampling the CUT output repeatedly.
- Flags oscillating or metastable vectors as unstable, compares stable values against an expected truth table, and reports per-vector results plus a fitness count.
- Sits between the host/evaluation logic and the CUT instance.

Parameters:
- IN_WIDTH, 4, CUT input width; number of vectors NV = 2**IN_WIDTH.
- SETTLE_CYCLES, 16, cycles dut_in is held before sampling begins; legal range >= 3, which covers the 2-flop synchronizer.
- SAMPLES, 8, consecutive per-cycle samples taken per vector; legal range >= 1.

Ports:
- clk  input  1  sole clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a run; accepted only in IDLE.
- abort  input  1  terminate a run and return to IDLE.
- expected  input  NV  expected output; bit k is the expected value for vector k. Latched at start.
- dut_in  output  IN_WIDTH  vector applied to the CUT.
- dut_out  input  1  CUT output; asynchronous, synchronized internally by 2 flops.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse when a run completes.
- result_vec  output  NV  sampled stable value per vector; 0 for unstable vectors.
- unstable_vec  output  NV  bit k set if vector k was unstable.
- match_count  output  IN_WIDTH+1  number of vectors that were stable and equal to expected.
- unstable_count  output  IN_WIDTH+1  popcount of unstable_vec.

Behaviour:
- Clock and reset: one clock. rst_n is asynchronous and active-low.
- Reset values: state=IDLE; dut_in=0; busy=0; done=0; result_vec=0; unstable_vec=0; match_count=0; unstable_count=0; synchronizer flops=0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 and abort=0: latch expected, clear all result outputs and counters, set vec=0, dut_in=0, busy=1, settle counter=0.
  - Next state SETTLE.
- SETTLE:
  - Hold dut_in=vec for SETTLE_CYCLES cycles.
  - Then clear the sample counter, capture first_sample from the synchronized dut_out, and go to SAMPLE.
- SAMPLE:
  - One synchronized sample per cycle, SAMPLES cycles in total, including the first.
  - Any sample != first_sample marks the vector unstable.
  - On the last sample cycle, if stable: result_vec[vec]=first_sample, and match_count increments when first_sample==expected[vec].
  - On the last sample cycle, if unstable: unstable_vec[vec]=1 and unstable_count increments. The vector is not counted as a match.
  - Then, if vec==NV-1, go to DONE. Otherwise vec+1, dut_in updates on the same edge, and go to SETTLE.
- DONE:
  - done=1 and busy=0 for exactly this cycle. Next state IDLE.
  - Results are held until the next accepted start or reset.
- Latency: each vector occupies SETTLE_CYCLES+SAMPLES cycles.
  - done asserts NV*(SETTLE_CYCLES+SAMPLES)+1 cycles after the start edge.
  - With defaults this is 385 cycles.
- vec is IN_WIDTH+1 bits internally, so the last-vector compare does not wrap. dut_in never exceeds NV-1.
- start while busy or in DONE: ignored; the latched expected is unchanged.
- abort in SETTLE or SAMPLE:
  - Next cycle: IDLE, busy=0, dut_in=0, no done pulse.
  - Partial results remain visible and are not valid.
- abort in IDLE or DONE: no effect. start and abort together in IDLE: abort wins, nothing starts.
- rst_n low mid-run: immediate return to reset values, with no done pulse.
- Counters saturate by construction at NV, which fits in IN_WIDTH+1 bits.

Test Plan:
- Parity check: CUT model out=^in, expected=16'h6996, start pulse -> done at cycle 385, match_count=16, unstable_count=0, result_vec=16'h6996, unstable_vec=0; dut_in steps 0..15 every 24 cycles.
- Expected mismatch: same CUT, expected=16'h0000 -> match_count=8, unstable_count=0, result_vec=16'h6996.
- Oscillation: CUT toggles every cycle while dut_in==5, otherwise parity; expected=16'h6996 -> unstable_vec=16'h0020, unstable_count=1, match_count=15, result_vec[5]=0.
- Abort: abort pulse at cycle 100 after start -> busy=0 and dut_in=0 on the next cycle, no done pulse. A fresh start then completes normally with 385-cycle latency.
- Start during a run: start re-pulsed at cycle 50 with expected=16'hFFFF -> ignored; the run finishes at cycle 385 using the original expected.
- Reset mid-run: rst_n low at cycle 200 -> all outputs 0 asynchronously, state IDLE.
- Back-to-back runs: start held high continuously -> a new run begins the cycle after DONE, and results are cleared at that start.

Source files
------------

// File: rtl/evo_truth_table_tester_if.sv
// Host-side bundle for the evolved-circuit truth-table tester.
// The host drives run control; the tester returns status and results.
interface evo_truth_table_tester_if #(
    parameter int IN_WIDTH = 4
);
    localparam int NV = 2 ** IN_WIDTH;

    logic                start;
    logic                abort;
    logic [NV-1:0]       expected;
    logic                busy;
    logic                done;
    logic [NV-1:0]       result_vec;
    logic [NV-1:0]       unstable_vec;
    logic [IN_WIDTH:0]   match_count;
    logic [IN_WIDTH:0]   unstable_count;

    modport master (
        output start,
        output abort,
        output expected,
        input  busy,
        input  done,
        input  result_vec,
        input  unstable_vec,
        input  match_count,
        input  unstable_count
    );

    modport slave (
        input  start,
        input  abort,
        input  expected,
        output busy,
        output done,
        output result_vec,
        output unstable_vec,
        output match_count,
        output unstable_count
    );
endinterface

// File: rtl/evo_truth_table_tester.sv
// Exhaustive truth-table sequencer for one evolved LCELL CUT.
// Settles each vector, samples the synchronized output, scores stability and fitness.
module evo_truth_table_tester #(
    parameter int IN_WIDTH      = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int SAMPLES       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    evo_truth_table_tester_if.slave bus,
    output logic [IN_WIDTH-1:0]  dut_in,
    input  logic                 dut_out
);
    localparam int NV  = 2 ** IN_WIDTH;
    localparam int VW  = IN_WIDTH + 1;
    localparam int SCW = $clog2(SETTLE_CYCLES + 1);
    localparam int SMW = $clog2(SAMPLES + 1);

    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
    localparam logic [SMW-1:0] SAMPLE_LAST = SMW'(SAMPLES - 1);
    localparam logic [VW-1:0]  VEC_LAST    = VW'(NV - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]          r_state;
    logic [VW-1:0]       r_vec;
    logic [SCW-1:0]      r_scnt;
    logic [SMW-1:0]      r_mcnt;
    logic                r_first;
    logic                r_unst;
    logic [NV-1:0]       r_exp;
    logic [NV-1:0]       r_res;
    logic [NV-1:0]       r_uvec;
    logic [VW-1:0]       r_match;
    logic [VW-1:0]       r_ucnt;
    logic                r_busy;
    logic                r_done;
    logic                r_sync1;
    logic                r_sync2;
    logic [IN_WIDTH-1:0] r_dut_in;

    logic [IN_WIDTH-1:0] w_idx;
    logic [VW-1:0]       w_vec_nxt;
    logic                w_unst;

    assign w_idx     = r_vec[IN_WIDTH-1:0];
    assign w_vec_nxt = r_vec + VW'(1);
    // Instability is sticky across the sample window of one vector.
    assign w_unst    = r_unst | (r_sync2 != r_first);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_vec    <= '0;
            r_scnt   <= '0;
            r_mcnt   <= '0;
            r_first  <= 1'b0;
            r_unst   <= 1'b0;
            r_exp    <= '0;
            r_res    <= '0;
            r_uvec   <= '0;
            r_match  <= '0;
            r_ucnt   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_dut_in <= '0;
        end else begin
            r_sync1 <= dut_out;
            r_sync2 <= r_sync1;
            r_done  <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        r_exp    <= bus.expected;
                        r_res    <= '0;
                        r_uvec   <= '0;
                        r_match  <= '0;
                        r_ucnt   <= '0;
                        r_vec    <= '0;
                        r_dut_in <= '0;
                        r_scnt   <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (bus.abort) begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_dut_in <= '0;
                    end else if (r_scnt == SETTLE_LAST) begin
                        r_mcnt  <= '0;
                        r_first <= r_sync2;
                        r_unst  <= 1'b0;
                        r_state <= S_SAMPLE;
                    end else begin
                        r_scnt <= r_scnt + SCW'(1);
                    end
                end
                S_SAMPLE: begin
                    if (bus.abort) begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_dut_in <= '0;
                    end else if (r_mcnt == SAMPLE_LAST) begin
                        if (w_unst) begin
                            r_uvec[w_idx] <= 1'b1;
                            r_ucnt        <= r_ucnt + VW'(1);
                        end else begin
                            r_res[w_idx] <= r_first;
                            if (r_first == r_exp[w_idx])
                                r_match <= r_match + VW'(1);
                        end
                        if (r_vec == VEC_LAST) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_vec    <= w_vec_nxt;
                            r_dut_in <= w_vec_nxt[IN_WIDTH-1:0];
                            r_scnt   <= '0;
                            r_state  <= S_SETTLE;
                        end
                    end else begin
                        r_mcnt <= r_mcnt + SMW'(1);
                        r_unst <= w_unst;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign dut_in             = r_dut_in;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.result_vec     = r_res;
    assign bus.unstable_vec   = r_uvec;
    assign bus.match_count    = r_match;
    assign bus.unstable_count = r_ucnt;
endmodule
